// File: rtl/chu_pwm_pkg.sv
// chu_pwm_pkg: register map, CTRL bit positions and counting mode type for the PWM slot core
package chu_pwm_pkg;
  localparam logic [4:0] ADDR_DVSR    = 5'h00;
  localparam logic [4:0] ADDR_CTRL    = 5'h01;
  localparam logic [4:0] ADDR_POL     = 5'h02;
  localparam logic [4:0] ADDR_STATUS  = 5'h03;
  localparam logic [4:0] ADDR_IRQ_CLR = 5'h04;
  localparam logic [4:0] ADDR_DUTY    = 5'h10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;
  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
endpackage

// File: rtl/chu_io_pwm_dbuf_core_if.sv
// chu_io_pwm_dbuf_core_if: MMIO slot bus between the bus master and the PWM core
interface chu_io_pwm_dbuf_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/pwm_period_gen.sv
// pwm_period_gen: shared prescaler plus edge/center up-down period counter
module pwm_period_gen
  import chu_pwm_pkg::*;
#(
  parameter int R = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  pwm_mode_t   mode,
  input  logic [31:0] dvsr,
  output logic [R-1:0] d,
  output logic        dir,
  output logic        tick,
  output logic        boundary
);
  localparam logic [R-1:0] M = '1;
  localparam logic [R-1:0] ONE = R'(1);
  logic [31:0] q;
  logic [R-1:0] d_next;
  logic dir_next;
  assign tick = en && q == dvsr;
  assign boundary = tick && d_next == '0;
  always_comb begin
    d_next = mode == PWM_EDGE ? d + ONE : (dir || d == M) ? d - ONE : d + ONE;
    // direction is always up when the counter returns to zero
    dir_next = mode == PWM_CENTER && d_next != '0 && (dir ? d != ONE : d == M);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q <= '0;
      d <= '0;
      dir <= 1'b0;
    end else if (!en) begin
      q <= '0;
      d <= '0;
      dir <= 1'b0;
    end else begin
      q <= q == dvsr ? '0 : q + 32'd1;
      if (tick) begin
        d <= d_next;
        dir <= dir_next;
      end
    end
endmodule

// File: rtl/chu_io_pwm_dbuf_core.sv
// chu_io_pwm_dbuf_core: W-channel double-buffered edge/center PWM with polarity and readback
// Optional sticky boundary interrupt enabled by defining PWM_IRQ_EN.
module chu_io_pwm_dbuf_core
  import chu_pwm_pkg::*;
#(
  parameter int W = 6,
  parameter int R = 10
) (
  input  logic clk,
  input  logic reset_n,
  chu_io_pwm_dbuf_core_if.slave bus,
  output logic [W-1:0] pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic irq
`endif
);
  logic [31:0] dvsr;
  logic [2:0] ctrl;
  logic [W-1:0] pol, raw;
  logic [R:0] shadow [W];
  logic [R:0] duty [W];
  pwm_mode_t act_mode;
  logic [R-1:0] d;
  logic dir, tick, boundary, flag, wr, en, load, unused;
  assign wr = bus.cs && bus.write;
  assign en = ctrl[CTRL_EN];
  assign load = !en || boundary;
  assign unused = ^{bus.read, tick};
  pwm_period_gen #(.R(R)) u_gen (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(act_mode), .dvsr(dvsr),
    .d(d), .dir(dir), .tick(tick), .boundary(boundary)
  );
  always_comb begin
    raw = '0;
    for (int i = 0; i < W; i++) raw[i] = {1'b0, d} < duty[i];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dvsr <= '0;
      ctrl <= '0;
      pol <= '0;
      act_mode <= PWM_EDGE;
      pwm_out <= '0;
      for (int i = 0; i < W; i++) begin
        shadow[i] <= '0;
        duty[i] <= '0;
      end
    end else begin
      if (wr && bus.addr == ADDR_DVSR) dvsr <= bus.wr_data;
      if (wr && bus.addr == ADDR_CTRL) ctrl <= bus.wr_data[2:0];
      if (wr && bus.addr == ADDR_POL) pol <= bus.wr_data[W-1:0];
      for (int i = 0; i < W; i++)
        if (wr && bus.addr == ADDR_DUTY + 5'(i)) shadow[i] <= bus.wr_data[R:0];
      // actives track the shadow while stopped, otherwise only at period boundaries
      if (load) begin
        act_mode <= pwm_mode_t'(ctrl[CTRL_MODE]);
        for (int i = 0; i < W; i++) duty[i] <= shadow[i];
      end
      pwm_out <= (en ? raw : '0) ^ pol;
    end
`ifdef PWM_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) flag <= 1'b0;
    else flag <= boundary || (flag && !(wr && bus.addr == ADDR_IRQ_CLR));
  assign irq = flag && ctrl[CTRL_IRQ_EN];
`else
  assign flag = 1'b0;
`endif
  always_comb begin
    bus.rd_data = '0;
    if (bus.addr == ADDR_DVSR) bus.rd_data = dvsr;
    if (bus.addr == ADDR_CTRL) bus.rd_data = 32'(ctrl);
    if (bus.addr == ADDR_POL) bus.rd_data = 32'(pol);
    if (bus.addr == ADDR_STATUS) bus.rd_data = 32'({flag, dir, d});
    for (int i = 0; i < W; i++)
      if (bus.addr == ADDR_DUTY + 5'(i)) bus.rd_data = 32'(shadow[i]);
  end
endmodule
